// File: rtl/prach_nco_mc.sv
// prach_nco_mc: time-interleaved multi-channel NCO with per-channel modular phase accumulators, 4-cycle latency.
// Build option: define PRACH_NCO_MC_DITHER_EN to add LFSR phase dither ahead of LUT addressing.
module prach_nco_mc #(
    parameter int    NUM_CHN   = 8,
    parameter int    CHN_W     = 8,
    parameter int    PHASE_W   = 16,
    parameter int    PHASE_MOD = 49152,
    parameter int    LUT_AW    = 10,
    parameter int    DATA_W    = 16,
    parameter string LUT_FILE  = "prach_nco_sin_lut.hex"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            din_dv,
    input  logic [CHN_W-1:0]                din_chn,
    input  logic                            sync_in,
    input  logic [NUM_CHN-1:0][PHASE_W-1:0] ctrl_fcw,
    input  logic [NUM_CHN-1:0][PHASE_W-1:0] ctrl_phase_ofs,
    output logic signed [DATA_W-1:0]        dout_cos,
    output logic signed [DATA_W-1:0]        dout_sin,
    output logic                            dout_dv,
    output logic [CHN_W-1:0]                dout_chn,
    output logic                            sync_out
);
    localparam int                 LUT_SIZE = 1 << LUT_AW;
    localparam logic [PHASE_W:0]   MOD_X    = (PHASE_W+1)'(PHASE_MOD);
    localparam logic [PHASE_W-1:0] QTR      = PHASE_W'(PHASE_MOD / 4);

    function automatic logic [PHASE_W-1:0] mod_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
        logic [PHASE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_X) s = s - MOD_X;
        return s[PHASE_W-1:0];
    endfunction

    // Same table as LUT_FILE, generated at elaboration so the ROM has no file-path dependency.
    function automatic logic [DATA_W-1:0] sin_entry(input int k);
        real amp, ang, x;
        int  r;
        amp = real'((1 << (DATA_W-1)) - 1);
        ang = 6.283185307179586 * real'(k) * real'(1 << (PHASE_W-LUT_AW)) / real'(PHASE_MOD);
        x   = amp * $sin(ang);
        r   = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        return DATA_W'(r);
    endfunction

    logic [DATA_W-1:0] lut_rom [LUT_SIZE];
    for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
        localparam logic [DATA_W-1:0] ENTRY = sin_entry(k);
        assign lut_rom[k] = ENTRY;
    end

    logic [PHASE_W-1:0] acc     [NUM_CHN];
    logic [PHASE_W-1:0] fcw_act [NUM_CHN];
    logic [PHASE_W-1:0] p0;
    logic [PHASE_W-1:0] p0_eff;
    logic               chn_ok;

    always_comb begin
        chn_ok = ({1'b0, din_chn} < (CHN_W+1)'(NUM_CHN));
        p0     = '0;
        for (int c = 0; c < NUM_CHN; c++) begin
            if (din_chn == CHN_W'(c)) p0 = sync_in ? ctrl_phase_ofs[c] : acc[c];
        end
    end

    // A sample taken on the sync cycle consumes the new offset, so its channel resumes at offset+fcw.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                acc[c]     <= '0;
                fcw_act[c] <= '0;
            end
        end else if (sync_in) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                fcw_act[c] <= ctrl_fcw[c];
                if (din_dv && din_chn == CHN_W'(c))
                    acc[c] <= mod_add(ctrl_phase_ofs[c], ctrl_fcw[c]);
                else
                    acc[c] <= ctrl_phase_ofs[c];
            end
        end else if (din_dv) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                if (din_chn == CHN_W'(c)) acc[c] <= mod_add(acc[c], fcw_act[c]);
            end
        end
    end

`ifdef PRACH_NCO_MC_DITHER_EN
    localparam int DITH_W = PHASE_W - LUT_AW;
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (din_dv)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign p0_eff = mod_add(p0, {{LUT_AW{1'b0}}, lfsr[DITH_W-1:0]});
`else
    assign p0_eff = p0;
`endif

    logic               s1_dv, s2_dv, s3_dv;
    logic               s1_sync, s2_sync, s3_sync;
    logic               s1_ok, s2_ok, s3_ok;
    logic [CHN_W-1:0]   s1_chn, s2_chn, s3_chn;
    logic [PHASE_W-1:0] s1_p;
    logic [PHASE_W-1:0] s1_pc;
    logic [LUT_AW-1:0]  s2_sin_addr, s2_cos_addr;
    logic [DATA_W-1:0]  s3_sin, s3_cos;

    assign s1_pc = mod_add(s1_p, QTR);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_dv <= 1'b0; s2_dv <= 1'b0; s3_dv <= 1'b0; dout_dv <= 1'b0;
            s1_sync <= 1'b0; s2_sync <= 1'b0; s3_sync <= 1'b0; sync_out <= 1'b0;
            s1_ok <= 1'b0; s2_ok <= 1'b0; s3_ok <= 1'b0;
            s1_chn <= '0; s2_chn <= '0; s3_chn <= '0; dout_chn <= '0;
            s1_p <= '0;
            s2_sin_addr <= '0;
            s2_cos_addr <= '0;
            s3_sin <= '0;
            s3_cos <= '0;
            dout_sin <= '0;
            dout_cos <= '0;
        end else begin
            s1_dv   <= din_dv;
            s1_sync <= sync_in;
            s1_ok   <= chn_ok;
            s1_chn  <= din_chn;
            s1_p    <= p0_eff;

            s2_dv       <= s1_dv;
            s2_sync     <= s1_sync;
            s2_ok       <= s1_ok;
            s2_chn      <= s1_chn;
            s2_sin_addr <= s1_p[PHASE_W-1 -: LUT_AW];
            s2_cos_addr <= s1_pc[PHASE_W-1 -: LUT_AW];

            s3_dv   <= s2_dv;
            s3_sync <= s2_sync;
            s3_ok   <= s2_ok;
            s3_chn  <= s2_chn;
            s3_sin  <= lut_rom[s2_sin_addr];
            s3_cos  <= lut_rom[s2_cos_addr];

            dout_dv  <= s3_dv;
            sync_out <= s3_sync;
            dout_chn <= s3_chn;
            dout_sin <= s3_ok ? s3_sin : '0;
            dout_cos <= s3_ok ? s3_cos : '0;
        end
    end

endmodule

// File: tb/tb_prach_nco_mc.sv
// tb_prach_nco_mc: directed and random stimulus against a modular-arithmetic reference model of the NCO.
module tb_prach_nco_mc;
    localparam int NUM_CHN = 8;
    localparam int PW      = 16;
    localparam int MOD     = 49152;
    localparam int AW      = 10;
    localparam int DW      = 16;
    localparam int SHIFT   = 1 << (PW - AW);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       din_dv;
    logic [7:0]                 din_chn;
    logic                       sync_in;
    logic [NUM_CHN-1:0][PW-1:0] ctrl_fcw;
    logic [NUM_CHN-1:0][PW-1:0] ctrl_phase_ofs;
    logic [DW-1:0]              dout_cos;
    logic [DW-1:0]              dout_sin;
    logic                       dout_dv;
    logic [7:0]                 dout_chn;
    logic                       sync_out;

    prach_nco_mc #(
        .NUM_CHN(NUM_CHN), .CHN_W(8), .PHASE_W(PW), .PHASE_MOD(MOD),
        .LUT_AW(AW), .DATA_W(DW), .LUT_FILE("prach_nco_sin_lut.hex")
    ) dut (
        .clk(clk), .rst(rst), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
        .ctrl_fcw(ctrl_fcw), .ctrl_phase_ofs(ctrl_phase_ofs),
        .dout_cos(dout_cos), .dout_sin(dout_sin), .dout_dv(dout_dv),
        .dout_chn(dout_chn), .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [7:0] chn;
        logic       sync;
        logic       chk_data;
        logic [15:0] cos_v;
        logic [15:0] sin_v;
    } exp_t;

    exp_t        q[$];
    logic [15:0] lut [1 << AW];
    int          m_acc [NUM_CHN];
    int          m_fcw [NUM_CHN];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic step(input logic r, input logic dv, input int ch, input logic s);
        exp_t e;
        exp_t z;
        int   p;
        bit   ok;
        z = '{dv: 1'b0, chn: 8'd0, sync: 1'b0, chk_data: 1'b1, cos_v: 16'd0, sin_v: 16'd0};
        rst = r; din_dv = dv; din_chn = 8'(ch); sync_in = s;
        e = z;
        if (r) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                m_acc[c] = 0;
                m_fcw[c] = 0;
            end
            q.delete();
            repeat (3) q.push_back(z);
        end else begin
            ok = (ch < NUM_CHN);
            p  = 0;
            e.dv = dv; e.chn = 8'(ch); e.sync = s; e.chk_data = dv;
            if (s) begin
                for (int c = 0; c < NUM_CHN; c++) begin
                    m_fcw[c] = int'(ctrl_fcw[c]);
                    m_acc[c] = int'(ctrl_phase_ofs[c]);
                end
                if (ok) p = m_acc[ch];
                if (dv && ok) m_acc[ch] = (m_acc[ch] + m_fcw[ch]) % MOD;
            end else if (dv && ok) begin
                p = m_acc[ch];
                m_acc[ch] = (p + m_fcw[ch]) % MOD;
            end
            if (dv && ok) begin
                e.sin_v = lut[p / SHIFT];
                e.cos_v = lut[((p + MOD / 4) % MOD) / SHIFT];
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() >= 4) begin
            e = q.pop_front();
            chk("dout_dv", 32'(dout_dv), 32'(e.dv));
            chk("dout_chn", 32'(dout_chn), 32'(e.chn));
            chk("sync_out", 32'(sync_out), 32'(e.sync));
            if (e.chk_data) begin
                chk("dout_cos", 32'(dout_cos), 32'(e.cos_v));
                chk("dout_sin", 32'(dout_sin), 32'(e.sin_v));
            end
        end
    endtask

    initial begin
        real x;
        int  r;
        int  ch;
        int  prev_ch;
        for (int k = 0; k < (1 << AW); k++) begin
            x = 32767.0 * $sin(6.283185307179586 * real'(k) * real'(SHIFT) / real'(MOD));
            r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
            lut[k] = 16'(r);
        end
        rst = 1'b1; din_dv = 1'b0; din_chn = '0; sync_in = 1'b0;
        ctrl_fcw = '0; ctrl_phase_ofs = '0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // fcw 64 on ch0: sin walks lut[0..], cos starts at lut[192]
        ctrl_fcw[0] = 16'd64;
        step(0, 0, 0, 1);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);

        // wrap on ch3: phases 0, 49088, 49024
        ctrl_fcw[3] = 16'd49088;
        step(0, 0, 0, 1);
        repeat (3) step(0, 1, 3, 0);

        // shadow fcw/offset only take effect at sync
        ctrl_fcw[1] = 16'd64; ctrl_phase_ofs[1] = 16'd1000;
        step(0, 0, 0, 1);
        repeat (3) step(0, 1, 1, 0);
        ctrl_fcw[1] = 16'd128; ctrl_phase_ofs[1] = 16'd5000;
        repeat (3) step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 1, 1, 0);

        // round robin with an out-of-range channel inserted
        for (int c = 0; c < NUM_CHN; c++) ctrl_fcw[c] = 16'(100 * (c + 1) + 7);
        step(0, 0, 0, 1);
        for (int rr = 0; rr < 3; rr++) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                step(0, 1, c, 0);
                if (c == 3) step(0, 1, 9, 0);
            end
        end

        // sync coincident with a ch2 sample
        ctrl_phase_ofs[2] = 16'd12288;
        step(0, 1, 2, 1);
        step(0, 1, 5, 0);
        step(0, 1, 2, 0);

        // reset with three samples in flight
        step(0, 1, 1, 0);
        step(0, 1, 2, 0);
        step(0, 1, 3, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        prev_ch = 0;
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                if ($urandom_range(0, 15) == 0) ctrl_fcw[c] = 16'($urandom_range(0, MOD - 1));
                if ($urandom_range(0, 15) == 0) ctrl_phase_ofs[c] = 16'($urandom_range(0, MOD - 1));
            end
            ch = ($urandom_range(0, 3) == 0) ? prev_ch : int'($urandom_range(0, 10));
            prev_ch = ch;
            step(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ch,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
        end
        repeat (4) step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
